// File: rtl/data_ram_bridge_pkg.sv
// Shared definitions for the data RAM bridge: bus widths, timeout limit
// and FSM state encoding. Optional feature macro: DATA_BUS_TIMEOUT_EN.
package data_ram_bridge_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int STRB_W = 4;
    localparam int CNT_W  = 8;

    localparam logic [CNT_W-1:0] TIMEOUT_LIMIT = 8'd255;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } bridge_state_t;

endpackage

// File: rtl/data_ram_bridge_timeout_cnt.sv
// Bus timeout counter: counts cycles an access spends in flight and flags
// when the limit is reached. Only instantiated with DATA_BUS_TIMEOUT_EN.
module bus_timeout_cnt
    import data_ram_bridge_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [CNT_W-1:0] count;

    // Hold at zero outside an access, count up while one is in flight, stop at the limit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != TIMEOUT_LIMIT)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == TIMEOUT_LIMIT);

endmodule

// File: rtl/data_ram_bridge.sv
// Data RAM bridge: turns MEM-stage load/store requests into a registered
// request/response handshake on the data bus, stalling the pipeline while
// the access is in flight. Flushed accesses finish on the bus silently.
// Optional macro DATA_BUS_TIMEOUT_EN adds an 8-bit bus timeout with bus_error.
module data_ram_bridge
    import data_ram_bridge_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              ram_en,
    input  logic [STRB_W-1:0] ram_write_en,
    input  logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_write_data,
    input  logic              flush,
    output logic [DATA_W-1:0] ram_read_data,
    output logic              stall_request,
    output logic              bus_req,
    output logic [STRB_W-1:0] bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ready,
    input  logic              bus_rvalid,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              bus_error
);

    bridge_state_t state;
    bridge_state_t next_state;

    logic cancel;
    logic cancel_eff;
    logic in_flight;
    logic is_write;
    logic start;
    logic capture;
    logic timeout_evt;
    logic timeout_hit;

    assign in_flight  = (state == S_REQ) || (state == S_WAIT);
    assign is_write   = |bus_we;
    assign cancel_eff = cancel | flush;

`ifdef DATA_BUS_TIMEOUT_EN
    bus_timeout_cnt u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (!in_flight),
        .enable  (in_flight),
        .expired (timeout_hit)
    );

    // One-cycle error pulse on the edge that abandons a timed-out access
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_error <= 1'b0;
        end else begin
            bus_error <= timeout_evt;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign bus_error   = 1'b0;
`endif

    // Next-state decode; a real bus response always wins over a timeout
    always_comb begin
        next_state  = state;
        start       = 1'b0;
        capture     = 1'b0;
        timeout_evt = 1'b0;
        case (state)
            S_IDLE: begin
                if (ram_en && !flush) begin
                    next_state = S_REQ;
                    start      = 1'b1;
                end
            end
            S_REQ: begin
                if (bus_ready) begin
                    if (!is_write) begin
                        next_state = S_WAIT;
                    end else if (cancel_eff) begin
                        next_state = S_IDLE;
                    end else begin
                        next_state = S_DONE;
                    end
                end else if (timeout_hit) begin
                    timeout_evt = 1'b1;
                    next_state  = cancel_eff ? S_IDLE : S_DONE;
                end
            end
            S_WAIT: begin
                if (bus_rvalid) begin
                    if (cancel_eff) begin
                        next_state = S_IDLE;
                    end else begin
                        next_state = S_DONE;
                        capture    = 1'b1;
                    end
                end else if (timeout_hit) begin
                    timeout_evt = 1'b1;
                    next_state  = cancel_eff ? S_IDLE : S_DONE;
                end
            end
            S_DONE: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    assign stall_request = ((state == S_IDLE) && ram_en) || in_flight;

    // State register and registered bus request, asserted exactly while in REQ
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            bus_req <= 1'b0;
        end else begin
            state   <= next_state;
            bus_req <= (next_state == S_REQ);
        end
    end

    // Latch the request fields when an access starts; they stay stable afterwards
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_we    <= '0;
            bus_addr  <= '0;
            bus_wdata <= '0;
        end else if (start) begin
            bus_we    <= ram_write_en;
            bus_addr  <= ram_addr;
            bus_wdata <= ram_write_data;
        end
    end

    // Remember a flush seen mid-access so the completion is swallowed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cancel <= 1'b0;
        end else if (in_flight) begin
            cancel <= cancel_eff;
        end else begin
            cancel <= 1'b0;
        end
    end

    // Load data only changes on a good read response or a read timeout
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_read_data <= '0;
        end else if (capture) begin
            ram_read_data <= bus_rdata;
        end else if (timeout_evt && !cancel_eff && !is_write) begin
            ram_read_data <= '0;
        end
    end

endmodule

// File: tb/tb_data_ram_bridge.sv
// Directed self-checking bench for data_ram_bridge: write, read, back-to-back,
// flush, reset and timeout (DATA_BUS_TIMEOUT_EN) or wait-forever behaviour.
module tb_data_ram_bridge;

    logic        clk;
    logic        rst;
    logic        ram_en;
    logic [3:0]  ram_write_en;
    logic [31:0] ram_addr;
    logic [31:0] ram_write_data;
    logic        flush;
    logic [31:0] ram_read_data;
    logic        stall_request;
    logic        bus_req;
    logic [3:0]  bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ready;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    logic        bus_error;

    int n_checks;
    int n_fail;
    int req_episodes;
    logic req_prev;

    data_ram_bridge dut (
        .clk            (clk),
        .rst            (rst),
        .ram_en         (ram_en),
        .ram_write_en   (ram_write_en),
        .ram_addr       (ram_addr),
        .ram_write_data (ram_write_data),
        .flush          (flush),
        .ram_read_data  (ram_read_data),
        .stall_request  (stall_request),
        .bus_req        (bus_req),
        .bus_we         (bus_we),
        .bus_addr       (bus_addr),
        .bus_wdata      (bus_wdata),
        .bus_ready      (bus_ready),
        .bus_rvalid     (bus_rvalid),
        .bus_rdata      (bus_rdata),
        .bus_error      (bus_error)
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count rising edges of bus_req, sampled away from the active edge
    always @(negedge clk) begin
        if (bus_req === 1'b1 && req_prev !== 1'b1) begin
            req_episodes++;
        end
        req_prev = bus_req;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic en, input logic [3:0] we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic fl, input logic rdy,
                                 input logic rv, input logic [31:0] rdata);
        ram_en         = en;
        ram_write_en   = we;
        ram_addr       = addr;
        ram_write_data = wdata;
        flush          = fl;
        bus_ready      = rdy;
        bus_rvalid     = rv;
        bus_rdata      = rdata;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        int waited;
        n_checks     = 0;
        n_fail       = 0;
        req_episodes = 0;
        req_prev     = 1'b0;
        rst          = 1'b1;
        applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        tick();

        // Reset state
        checkOutput("rst_bus_req", {31'd0, bus_req}, 32'd0);
        checkOutput("rst_bus_we", {28'd0, bus_we}, 32'd0);
        checkOutput("rst_bus_addr", bus_addr, 32'd0);
        checkOutput("rst_bus_wdata", bus_wdata, 32'd0);
        checkOutput("rst_rdata", ram_read_data, 32'd0);
        checkOutput("rst_bus_error", {31'd0, bus_error}, 32'd0);
        checkOutput("rst_stall", {31'd0, stall_request}, 32'd0);
        rst = 1'b0;
        tick();

        // Write, zero wait states: stall in IDLE and REQ only
        applyStimulus(1'b1, 4'b0011, 32'h100, 32'h0000ABCD, 1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("wr_idle_stall", {31'd0, stall_request}, 32'd1);
        checkOutput("wr_idle_req", {31'd0, bus_req}, 32'd0);
        tick();
        checkOutput("wr_req_bus_req", {31'd0, bus_req}, 32'd1);
        checkOutput("wr_req_we", {28'd0, bus_we}, 32'h3);
        checkOutput("wr_req_addr", bus_addr, 32'h100);
        checkOutput("wr_req_wdata", bus_wdata, 32'h0000ABCD);
        checkOutput("wr_req_stall", {31'd0, stall_request}, 32'd1);
        tick();
        applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("wr_done_stall", {31'd0, stall_request}, 32'd0);
        checkOutput("wr_done_req", {31'd0, bus_req}, 32'd0);
        tick();
        checkOutput("wr_idle_after", {31'd0, bus_req}, 32'd0);

        // Read: ready after 2 REQ cycles, rvalid on 3rd WAIT cycle; stray rvalid in REQ ignored
        applyStimulus(1'b1, 4'h0, 32'h200, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b1, 4'h0, 32'h200, 32'h0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF);
        checkOutput("rd_req1", {31'd0, bus_req}, 32'd1);
        checkOutput("rd_req1_addr", bus_addr, 32'h200);
        tick();
        applyStimulus(1'b1, 4'h0, 32'h200, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("rd_req2", {31'd0, bus_req}, 32'd1);
        tick();
        applyStimulus(1'b1, 4'h0, 32'h200, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("rd_wait1_req", {31'd0, bus_req}, 32'd0);
        checkOutput("rd_wait1_stall", {31'd0, stall_request}, 32'd1);
        checkOutput("rd_stray_rvalid", ram_read_data, 32'd0);
        tick();
        tick();
        applyStimulus(1'b1, 4'h0, 32'h200, 32'h0, 1'b0, 1'b0, 1'b1, 32'h12345678);
        checkOutput("rd_wait3_stall", {31'd0, stall_request}, 32'd1);
        tick();
        applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("rd_done_data", ram_read_data, 32'h12345678);
        checkOutput("rd_done_stall", {31'd0, stall_request}, 32'd0);
        tick();
        checkOutput("rd_hold_data", ram_read_data, 32'h12345678);

        // Back-to-back writes: second instruction presented during DONE
        req_episodes = 0;
        applyStimulus(1'b1, 4'b1111, 32'h300, 32'h11111111, 1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        checkOutput("b2b_req1", {31'd0, bus_req}, 32'd1);
        tick();
        applyStimulus(1'b1, 4'b1100, 32'h304, 32'h22222222, 1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("b2b_done_req", {31'd0, bus_req}, 32'd0);
        checkOutput("b2b_done_stall", {31'd0, stall_request}, 32'd0);
        tick();
        checkOutput("b2b_idle_req", {31'd0, bus_req}, 32'd0);
        checkOutput("b2b_idle_stall", {31'd0, stall_request}, 32'd1);
        tick();
        checkOutput("b2b_req2", {31'd0, bus_req}, 32'd1);
        checkOutput("b2b_req2_addr", bus_addr, 32'h304);
        checkOutput("b2b_req2_we", {28'd0, bus_we}, 32'hC);
        checkOutput("b2b_req2_wdata", bus_wdata, 32'h22222222);
        tick();
        applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        tick();
        checkOutput("b2b_episodes", req_episodes, 32'd2);

        // Flush in WAIT: completion swallowed, stall held until rvalid, back to IDLE
        applyStimulus(1'b1, 4'h0, 32'h400, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        tick();
        applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("fl_wait1_stall", {31'd0, stall_request}, 32'd1);
        tick();
        applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("fl_wait2_stall", {31'd0, stall_request}, 32'd1);
        tick();
        applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFF);
        checkOutput("fl_wait3_stall", {31'd0, stall_request}, 32'd1);
        tick();
        applyStimulus(1'b1, 4'h0, 32'h404, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("fl_rdata_kept", ram_read_data, 32'h12345678);
        checkOutput("fl_back_idle", {31'd0, stall_request}, 32'd1);
        tick();
        checkOutput("fl_idle_suppress", {31'd0, bus_req}, 32'd0);
        applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();

        // Reset asserted in WAIT: immediate clear, later rvalid ignored
        applyStimulus(1'b1, 4'h0, 32'h500, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        tick();
        applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("rs_pre_addr", bus_addr, 32'h500);
        rst = 1'b1;
        #1;
        checkOutput("rs_async_addr", bus_addr, 32'd0);
        checkOutput("rs_async_rdata", ram_read_data, 32'd0);
        checkOutput("rs_async_stall", {31'd0, stall_request}, 32'd0);
        checkOutput("rs_async_req", {31'd0, bus_req}, 32'd0);
        tick();
        rst = 1'b0;
        applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hCAFEBABE);
        tick();
        applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("rs_late_rvalid", ram_read_data, 32'd0);
        checkOutput("rs_late_stall", {31'd0, stall_request}, 32'd0);

        // Zero-wait read to give ram_read_data a nonzero value
        applyStimulus(1'b1, 4'h0, 32'h700, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        checkOutput("zw_req_stall", {31'd0, stall_request}, 32'd1);
        tick();
        applyStimulus(1'b1, 4'h0, 32'h700, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0BADF00D);
        checkOutput("zw_wait_stall", {31'd0, stall_request}, 32'd1);
        tick();
        applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("zw_done_data", ram_read_data, 32'h0BADF00D);
        checkOutput("zw_done_stall", {31'd0, stall_request}, 32'd0);
        tick();

        // Read with bus_ready held low
        applyStimulus(1'b1, 4'h0, 32'h600, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("to_req", {31'd0, bus_req}, 32'd1);
`ifdef DATA_BUS_TIMEOUT_EN
        waited = 0;
        while (bus_error !== 1'b1 && waited < 400) begin
            tick();
            waited++;
        end
        checkOutput("to_latency", waited, 32'd256);
        applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("to_req_dropped", {31'd0, bus_req}, 32'd0);
        checkOutput("to_done_stall", {31'd0, stall_request}, 32'd0);
        checkOutput("to_rdata_zero", ram_read_data, 32'd0);
        tick();
        checkOutput("to_pulse_end", {31'd0, bus_error}, 32'd0);
`else
        waited = 0;
        repeat (300) begin
            tick();
            waited++;
        end
        checkOutput("nt_still_req", {31'd0, bus_req}, 32'd1);
        checkOutput("nt_no_error", {31'd0, bus_error}, 32'd0);
        checkOutput("nt_stall", {31'd0, stall_request}, 32'd1);
        applyStimulus(1'b1, 4'h0, 32'h600, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b1, 4'h0, 32'h600, 32'h0, 1'b0, 1'b0, 1'b1, 32'h55AA55AA);
        tick();
        applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("nt_done_data", ram_read_data, 32'h55AA55AA);
        checkOutput("nt_done_stall", {31'd0, stall_request}, 32'd0);
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
